// File: rtl/updown_mod_counter.sv
// Modulo-MOD up/down counter with load, wrap/saturate mode and a clock-enable prescaler.
// Emits a terminal-count look-ahead (tc) and a one-cycle wrap/limit pulse (wrap).
module updown_mod_counter #(
    parameter int W     = 8,
    parameter int MOD   = 256,
    parameter int PRESC = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         sat,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         tc,
    output logic         wrap
);

    // The modulus itself may not fit in W bits, so only MOD-1 is ever formed.
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [W-1:0]  MAXC  = W'(MOD - 1);
    localparam logic [PW-1:0] PLAST = PW'(PRESC - 1);

    logic [PW-1:0] p;
    logic          step;
    logic          at_limit;
    logic [W-1:0]  load_clamped;

    assign step         = en && (p == PLAST);
    assign at_limit     = up ? (count == MAXC) : (count == '0);
    assign tc           = step && at_limit;
    assign load_clamped = (load_val > MAXC) ? MAXC : load_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            p     <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            p     <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (en) begin
                p <= (p == PLAST) ? '0 : p + 1'b1;
            end
            // A step at the range limit always pulses wrap; sat only decides whether count moves.
            if (step) begin
                if (at_limit) begin
                    wrap <= 1'b1;
                    if (!sat) begin
                        count <= up ? '0 : MAXC;
                    end
                end else begin
                    count <= up ? count + 1'b1 : count - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench: three counter instances (defaults, MOD=10, MOD=4/PRESC=3) share
// one stimulus stream; each directed step pushes its expected outputs to a scoreboard.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       sat = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;

    logic [7:0] count_a, count_b, count_c;
    logic       tc_a, tc_b, tc_c;
    logic       wrap_a, wrap_b, wrap_c;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        int         which;
        logic [7:0] count;
        logic       tc;
        logic       wrap;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    updown_mod_counter #(.W(8), .MOD(256), .PRESC(1)) dut_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .count(count_a), .tc(tc_a), .wrap(wrap_a)
    );

    updown_mod_counter #(.W(8), .MOD(10), .PRESC(1)) dut_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .count(count_b), .tc(tc_b), .wrap(wrap_b)
    );

    updown_mod_counter #(.W(8), .MOD(4), .PRESC(3)) dut_c (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .count(count_c), .tc(tc_c), .wrap(wrap_c)
    );

    task automatic checkOutput();
        exp_t       e;
        logic [7:0] obs_count;
        logic       obs_tc;
        logic       obs_wrap;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty observed=0 entries required=1 entry");
            return;
        end
        e = sb.pop_front();
        case (e.which)
            0:       begin obs_count = count_a; obs_tc = tc_a; obs_wrap = wrap_a; end
            1:       begin obs_count = count_b; obs_tc = tc_b; obs_wrap = wrap_b; end
            default: begin obs_count = count_c; obs_tc = tc_c; obs_wrap = wrap_c; end
        endcase
        checks++;
        assert (obs_count === e.count) else begin
            failures++;
            $error("[TB] FAIL %s count observed=%0d expected=%0d", e.tag, obs_count, e.count);
        end
        checks++;
        assert (obs_tc === e.tc) else begin
            failures++;
            $error("[TB] FAIL %s tc observed=%0b expected=%0b", e.tag, obs_tc, e.tc);
        end
        checks++;
        assert (obs_wrap === e.wrap) else begin
            failures++;
            $error("[TB] FAIL %s wrap observed=%0b expected=%0b", e.tag, obs_wrap, e.wrap);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic applyStimulus(input logic r, input logic e_i, input logic u_i, input logic s_i,
                                 input logic l_i, input logic [7:0] lv, input int which,
                                 input logic [7:0] ec, input logic etc, input logic ewrap,
                                 input string tag);
        exp_t x;
        @(negedge clk);
        reset    = r;
        en       = e_i;
        up       = u_i;
        sat      = s_i;
        load     = l_i;
        load_val = lv;
        x.tag = tag; x.which = which; x.count = ec; x.tc = etc; x.wrap = ewrap;
        sb.push_back(x);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int c;
        int k;

        // Defaults: count up through 255 and wrap to 0.
        applyStimulus(1, 0, 1, 0, 0, 8'd0, 0, 8'd0, 0, 0, "a_reset");
        for (int i = 1; i <= 260; i++) begin
            c = i % 256;
            applyStimulus(0, 1, 1, 0, 0, 8'd0, 0, 8'(c), (c == 255), (i == 256), "a_up_wrap");
        end

        // Counter with MOD=10: down counting with wrap 0 -> 9.
        applyStimulus(1, 1, 0, 0, 0, 8'd0, 1, 8'd0, 1, 0, "b_reset_down");
        for (int i = 1; i <= 11; i++) begin
            c = (10 - (i % 10)) % 10;
            applyStimulus(0, 1, 0, 0, 0, 8'd0, 1, 8'(c), (c == 0), (i == 1 || i == 11), "b_down_wrap");
        end

        // Counter b, MOD=10 saturate: hold at 9 with a pulse on every limit step, then count back down.
        applyStimulus(0, 1, 1, 1, 1, 8'd7, 1, 8'd7, 0, 0, "b_load7");
        applyStimulus(0, 1, 1, 1, 0, 8'd0, 1, 8'd8, 0, 0, "b_sat_8");
        applyStimulus(0, 1, 1, 1, 0, 8'd0, 1, 8'd9, 1, 0, "b_sat_9");
        applyStimulus(0, 1, 1, 1, 0, 8'd0, 1, 8'd9, 1, 1, "b_sat_hold1");
        applyStimulus(0, 1, 1, 1, 0, 8'd0, 1, 8'd9, 1, 1, "b_sat_hold2");
        applyStimulus(0, 1, 0, 1, 0, 8'd0, 1, 8'd8, 0, 0, "b_sat_down8");
        applyStimulus(0, 1, 0, 1, 0, 8'd0, 1, 8'd7, 0, 0, "b_sat_down7");
        applyStimulus(0, 1, 0, 1, 0, 8'd0, 1, 8'd6, 0, 0, "b_sat_down6");

        // Load clamping, and load winning over en in the same cycle.
        applyStimulus(0, 0, 1, 0, 1, 8'd200, 1, 8'd9, 0, 0, "b_load_clamp");
        applyStimulus(0, 1, 1, 0, 1, 8'd3, 1, 8'd3, 0, 0, "b_load_over_en");
        applyStimulus(0, 0, 1, 0, 0, 8'd0, 1, 8'd3, 0, 0, "b_hold_en0");
        applyStimulus(0, 1, 1, 0, 1, 8'd9, 1, 8'd9, 1, 0, "b_load_max");
        applyStimulus(0, 1, 1, 0, 0, 8'd0, 1, 8'd0, 0, 1, "b_wrap_after_load");

        // Counter with MOD=4, PRESC=3: one step every third enabled cycle; phase survives en=0.
        applyStimulus(1, 0, 1, 0, 0, 8'd0, 2, 8'd0, 0, 0, "c_reset");
        k = 0;
        for (int i = 0; i < 4; i++) begin
            k++;
            c = (k / 3) % 4;
            applyStimulus(0, 1, 1, 0, 0, 8'd0, 2, 8'(c), (k % 3 == 2) && (c == 3),
                          (k % 3 == 0) && (c == 0), "c_presc");
        end
        applyStimulus(0, 0, 1, 0, 0, 8'd0, 2, 8'd1, 0, 0, "c_pause1");
        applyStimulus(0, 0, 1, 0, 0, 8'd0, 2, 8'd1, 0, 0, "c_pause2");
        for (int i = 0; i < 12; i++) begin
            k++;
            c = (k / 3) % 4;
            applyStimulus(0, 1, 1, 0, 0, 8'd0, 2, 8'(c), (k % 3 == 2) && (c == 3),
                          (k % 3 == 0) && (c == 0), "c_presc_resume");
        end

        // Reset mid-phase (count=1, p=1): clean restart, first step after three enabled cycles.
        applyStimulus(1, 1, 1, 0, 0, 8'd0, 2, 8'd0, 0, 0, "c_reset_mid");
        applyStimulus(0, 1, 1, 0, 0, 8'd0, 2, 8'd0, 0, 0, "c_after_reset1");
        applyStimulus(0, 1, 1, 0, 0, 8'd0, 2, 8'd0, 0, 0, "c_after_reset2");
        applyStimulus(0, 1, 1, 0, 0, 8'd0, 2, 8'd1, 0, 0, "c_after_reset3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
